// File: rtl/ms2pulses_pkg.sv
// Shared types and constants for the millisecond pulse-train generator.
package ms2pulses_pkg;

    // Controller states: waiting, timing a duration, one-cycle completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Durations wrap at this value, matching the pulse-count converter's range.
    localparam int MS_MOD = 1000;

    // Default width of millisecond values.
    localparam int DEFAULT_MS_W = 11;

    // Folds a requested duration into the 0..MS_MOD-1 range.
    function automatic int unsigned msModulo(input int unsigned value);
        return value % MS_MOD;
    endfunction

endpackage

// File: rtl/ms_tick_prescaler.sv
// Free-running clock-cycle prescaler that marks the last cycle of each millisecond.
module ms_tick_prescaler #(
    parameter int CLK_PER_MS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] r_count;

    // Count 0..CLK_PER_MS-1 while enabled; clear has priority so timing restarts at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            if (r_count == TERMINAL) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign tick = (r_count == TERMINAL);

endmodule

// File: rtl/ms2pulses.sv
// Converts a millisecond duration into a train of 1 ms tick pulses plus a done strobe.
module ms2pulses
    import ms2pulses_pkg::*;
#(
    parameter int CLK_PER_MS = 1000,
    parameter int MS_W       = DEFAULT_MS_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [MS_W-1:0] ms,
    input  logic            start,
    input  logic            abort,
    output logic            tick,
    output logic            busy,
    output logic            done,
    output logic [MS_W-1:0] remaining
);

    state_t          r_state;
    state_t          w_nextState;
    logic [MS_W-1:0] r_remaining;
    logic [MS_W-1:0] w_loadValue;
    logic            w_prescTick;
    logic            w_prescClr;
    logic            w_prescEn;
    logic            w_tick;
    logic            w_startAccepted;
    logic            w_decrement;
    logic            w_lastMs;

    // Requested durations are folded into 0..999 at load time.
    assign w_loadValue = MS_W'(msModulo(32'(ms)));

    // A restart while RUN needs an abort first; abort always wins over start.
    assign w_startAccepted = start && !abort && (r_state != RUN);

    // Tick comes purely from registers so no input reaches an output combinationally.
    assign w_tick = (r_state == RUN) && w_prescTick;

    // A tick that coincides with abort is shown but does not consume a millisecond.
    assign w_decrement = w_tick && !abort && (r_remaining != '0);
    assign w_lastMs    = (r_remaining == MS_W'(1));

    // Prescaler only runs in RUN and sits at zero otherwise, so every run starts aligned.
    assign w_prescEn  = (r_state == RUN);
    assign w_prescClr = (r_state != RUN) || abort;

    ms_tick_prescaler #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (w_prescClr),
        .en   (w_prescEn),
        .tick (w_prescTick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decision: abort first, then start/expiry handling per state.
    always_comb begin
        w_nextState = r_state;
        if (abort) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_startAccepted) begin
                        w_nextState = (w_loadValue == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_decrement && w_lastMs) begin
                        w_nextState = DONE;
                    end
                end
                DONE: begin
                    if (w_startAccepted) begin
                        w_nextState = (w_loadValue == '0) ? DONE : RUN;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // Remaining-time counter: load on an accepted start, count down on each tick, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
        end else if (w_startAccepted) begin
            r_remaining <= w_loadValue;
        end else if (w_decrement) begin
            r_remaining <= r_remaining - MS_W'(1);
        end
    end

    assign tick      = w_tick;
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign remaining = r_remaining;

endmodule

// File: tb/tb_ms2pulses.sv
// Scoreboard bench for ms2pulses driven by directed scenarios and random traffic.
module tb_ms2pulses;

    localparam int C = 4;
    localparam int W = 11;

    bit           clk;
    logic         reset;
    logic         start;
    logic         abort;
    logic [W-1:0] ms;
    logic         tick;
    logic         busy;
    logic         done;
    logic [W-1:0] remaining;

    typedef struct {
        bit tick;
        bit busy;
        bit done;
        int rem;
    } expT;

    expT expQ[$];
    int  checks;
    int  errors;

    // Reference model: a run is described by its loaded length and the cycles since start.
    bit mActive;
    int mN;
    int mK;
    int mHeld;

    ms2pulses #(
        .CLK_PER_MS(C),
        .MS_W      (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ms       (ms),
        .start    (start),
        .abort    (abort),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .remaining(remaining)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Expected outputs in the current cycle, derived from the timing rules of a run.
    function automatic expT modelOutputs();
        expT e;
        e.tick = 0;
        e.busy = 0;
        e.done = 0;
        e.rem  = mHeld;
        if (mActive) begin
            e.busy = (mK <= mN * C);
            e.tick = e.busy && ((mK % C) == 0);
            e.done = (mK == mN * C + 1);
            e.rem  = mN - (mK - 1) / C;
        end
        return e;
    endfunction

    // Drive one cycle of inputs, advance the model and queue the response for the next cycle.
    task automatic applyStimulus(input bit rst, input bit st, input bit ab, input int msVal);
        expT cur;
        cur   = modelOutputs();
        reset = rst;
        start = st;
        abort = ab;
        ms    = W'(msVal);
        if (rst) begin
            mActive = 0;
            mHeld   = 0;
        end else if (ab) begin
            mHeld   = cur.rem;
            mActive = 0;
        end else if (st && (!mActive || cur.done)) begin
            mActive = 1;
            mN      = msVal % 1000;
            mK      = 1;
        end else if (mActive) begin
            if (cur.done) begin
                mActive = 0;
                mHeld   = 0;
            end else begin
                mK++;
            end
        end
        expQ.push_back(modelOutputs());
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d required %0d", name, $time, actual, expected);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation mid-cycle.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("tick", 32'(tick), int'(e.tick));
                checkOutput("busy", 32'(busy), int'(e.busy));
                checkOutput("done", 32'(done), int'(e.done));
                checkOutput("remaining", 32'(remaining), e.rem);
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        int r;
        int msVal;
        bit st;
        bit ab;
        bit rst;
        checks  = 0;
        errors  = 0;
        mActive = 0;
        mN      = 0;
        mK      = 0;
        mHeld   = 0;

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        idleCycles(2);

        $display("[TB] basic run ms=3");
        applyStimulus(0, 1, 0, 3);
        idleCycles(15);

        $display("[TB] zero durations ms=0 and ms=1000");
        applyStimulus(0, 1, 0, 0);
        idleCycles(3);
        applyStimulus(0, 1, 0, 1000);
        idleCycles(3);

        $display("[TB] modulo load ms=1002");
        applyStimulus(0, 1, 0, 1002);
        idleCycles(11);

        $display("[TB] abort in cycle 6 of ms=5");
        applyStimulus(0, 1, 0, 5);
        idleCycles(5);
        applyStimulus(0, 0, 1, 0);
        idleCycles(4);
        applyStimulus(0, 1, 1, 3);
        idleCycles(3);

        $display("[TB] abort coinciding with a tick");
        applyStimulus(0, 1, 0, 2);
        idleCycles(3);
        applyStimulus(0, 0, 1, 0);
        idleCycles(3);

        $display("[TB] restart in DONE and start ignored in RUN");
        applyStimulus(0, 1, 0, 1);
        idleCycles(4);
        applyStimulus(0, 1, 0, 2);
        idleCycles(2);
        applyStimulus(0, 1, 0, 7);
        idleCycles(12);

        $display("[TB] reset mid-RUN then basic run");
        applyStimulus(0, 1, 0, 4);
        idleCycles(5);
        applyStimulus(1, 0, 0, 0);
        idleCycles(2);
        applyStimulus(0, 1, 0, 3);
        idleCycles(15);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            r   = int'($urandom_range(0, 199));
            rst = (r == 0);
            ab  = (r >= 1 && r <= 4);
            st  = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       msVal = int'($urandom_range(0, 3));
                1:       msVal = 1000 + int'($urandom_range(0, 5));
                2:       msVal = int'($urandom_range(4, 12));
                default: msVal = 2000 + int'($urandom_range(0, 47));
            endcase
            applyStimulus(rst, st, ab, msVal);
        end
        idleCycles(2);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
